// File: rtl/lz77_pkg.sv
// Shared types and widths for the LZ77 encoder control path.
// Combinational definitions only; no handshakes live here.
package lz77_pkg;
    localparam int WCHAR = 8;
    localparam int WOFF  = 4;
    localparam int WLEN  = 3;
    localparam int WIMG  = 12;
    localparam logic [WCHAR-1:0] END_SGN = 8'h24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FETCH,
        ST_EMIT
    } state_e;

    typedef struct packed {
        logic [WOFF-1:0]  offset;
        logic [WLEN-1:0]  len;
        logic [WCHAR-1:0] chr;
    } tok_t;
endpackage

// File: rtl/lz77_match_scheduler_if.sv
// Token output bus: (offset, len, char) plus finish, valid/ready handshake.
// The master holds every field stable while valid is high and ready is low.
interface lz77_match_scheduler_if;
    logic                       tok_valid;
    logic                       tok_ready;
    logic [lz77_pkg::WOFF-1:0]  tok_offset;
    logic [lz77_pkg::WLEN-1:0]  tok_len;
    logic [lz77_pkg::WCHAR-1:0] tok_char;
    logic                       finish;

    modport master (output tok_valid, tok_offset, tok_len, tok_char, finish, input tok_ready);
    modport slave  (input tok_valid, tok_offset, tok_len, tok_char, finish, output tok_ready);
endinterface

// File: rtl/lz77_best_match.sv
// Running-max tracker over search-window candidates, one candidate per cycle.
// Clipped length updates on strict improvement only; no backpressure, cleared by clr_i.
module lz77_best_match #(
    parameter int WIMG      = 12,
    parameter int STR_LEN   = 2049,
    parameter int MAX_MATCH = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr_i,
    input  logic                      upd_i,
    input  logic [lz77_pkg::WLEN-1:0] cmp_len_i,
    input  logic [WIMG-1:0]           cursor_i,
    input  logic [lz77_pkg::WOFF-1:0] off_i,
    output logic [lz77_pkg::WLEN-1:0] best_len_o,
    output logic [lz77_pkg::WOFF-1:0] best_off_o
);
    import lz77_pkg::*;

    localparam logic [WIMG-1:0] LAST_IDX = WIMG'(STR_LEN - 1);

    logic [WIMG-1:0] room;
    logic [WLEN-1:0] len_eff;
    logic [WLEN-1:0] best_len_q;
    logic [WOFF-1:0] best_off_q;

    // Clipping to the remaining room keeps cursor + len inside the string,
    // so the character after the match always exists.
    assign room = LAST_IDX - cursor_i;

    always_comb begin
        len_eff = cmp_len_i;
        if (len_eff > WLEN'(MAX_MATCH)) len_eff = WLEN'(MAX_MATCH);
        if (room < WIMG'(len_eff)) len_eff = room[WLEN-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best_len_q <= '0;
            best_off_q <= '0;
        end else if (clr_i) begin
            best_len_q <= '0;
            best_off_q <= '0;
        end else if (upd_i && (len_eff > best_len_q)) begin
            best_len_q <= len_eff;
            best_off_q <= off_i;
        end
    end

    assign best_len_o = best_len_q;
    assign best_off_o = best_off_q;
endmodule

// File: rtl/lz77_match_scheduler.sv
// LZ77 match scheduler: sweeps n = min(cursor, SB_LEN) candidates, then fetch, then emit one token.
// Latency n + 1 cycles to valid; token held stable until tok_ready, cursor advances only on handshake.
module lz77_match_scheduler #(
    parameter int         WIMG      = 12,
    parameter int         STR_LEN   = 2049,
    parameter int         SB_LEN    = 9,
    parameter int         MAX_MATCH = 7,
    parameter logic [7:0] END_SGN   = 8'h24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [WIMG-1:0]        cmp_sb,
    output logic [WIMG-1:0]        cmp_lb,
    input  logic [2:0]             cmp_len,
    output logic [WIMG-1:0]        char_addr,
    input  logic [7:0]             char_data,
    lz77_match_scheduler_if.master tok,
    output logic                   busy
);
    import lz77_pkg::*;

    state_e          state_q;
    logic [WIMG-1:0] cursor_q;
    logic [WIMG-1:0] cmp_sb_q;
    logic [WIMG-1:0] cmp_lb_q;
    logic [WOFF-1:0] off_q;
    tok_t            tok_q;
    logic            tok_valid_q;
    logic            finish_q;

    logic [WLEN-1:0] best_len;
    logic [WOFF-1:0] best_off;
    logic [WIMG-1:0] cursor_adv;
    logic            hs;
    logic            best_clr;
    logic            scan_last;

    function automatic logic [WOFF-1:0] win_depth(input logic [WIMG-1:0] c);
        return (c < WIMG'(SB_LEN)) ? c[WOFF-1:0] : WOFF'(SB_LEN);
    endfunction

    assign hs         = (state_q == ST_EMIT) && tok.tok_ready;
    assign best_clr   = ((state_q == ST_IDLE) && start) || hs;
    assign cursor_adv = cursor_q + WIMG'(best_len) + WIMG'(1);
    assign scan_last  = (off_q == (win_depth(cursor_q) - WOFF'(1)));
    assign char_addr  = cursor_q + WIMG'(best_len);

    lz77_best_match #(
        .WIMG      (WIMG),
        .STR_LEN   (STR_LEN),
        .MAX_MATCH (MAX_MATCH)
    ) u_best (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (best_clr),
        .upd_i      (state_q == ST_SCAN),
        .cmp_len_i  (cmp_len),
        .cursor_i   (cursor_q),
        .off_i      (off_q),
        .best_len_o (best_len),
        .best_off_o (best_off)
    );

    // cmp_sb/cmp_lb are loaded on entry to SCAN and stepped only inside it,
    // so the comparator inputs stay frozen through FETCH and EMIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cursor_q    <= '0;
            cmp_sb_q    <= '0;
            cmp_lb_q    <= '0;
            off_q       <= '0;
            tok_q       <= '0;
            tok_valid_q <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Cursor 0 has an empty window, so the first token skips SCAN.
                    if (start) begin
                        cursor_q <= '0;
                        off_q    <= '0;
                        state_q  <= ST_FETCH;
                    end
                end
                ST_SCAN: begin
                    if (scan_last) begin
                        state_q <= ST_FETCH;
                    end else begin
                        off_q    <= off_q + WOFF'(1);
                        cmp_sb_q <= cmp_sb_q - WIMG'(1);
                    end
                end
                ST_FETCH: begin
                    tok_q       <= '{offset: best_off, len: best_len, chr: char_data};
                    tok_valid_q <= 1'b1;
                    finish_q    <= (char_data == END_SGN);
                    state_q     <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (tok.tok_ready) begin
                        tok_valid_q <= 1'b0;
                        finish_q    <= 1'b0;
                        cursor_q    <= cursor_adv;
                        off_q       <= '0;
                        if (finish_q) begin
                            state_q <= ST_IDLE;
                        end else if (win_depth(cursor_adv) == '0) begin
                            state_q <= ST_FETCH;
                        end else begin
                            state_q  <= ST_SCAN;
                            cmp_sb_q <= cursor_adv - WIMG'(1);
                            cmp_lb_q <= cursor_adv;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmp_sb         = cmp_sb_q;
    assign cmp_lb         = cmp_lb_q;
    assign tok.tok_valid  = tok_valid_q;
    assign tok.tok_offset = tok_q.offset;
    assign tok.tok_len    = tok_q.len;
    assign tok.tok_char   = tok_q.chr;
    assign tok.finish     = finish_q;
    assign busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_lz77_match_scheduler.sv
// Scoreboard bench: an algorithmic encoder model fills the expected-token queue per run,
// tokens are popped and compared as the scheduler hands them over.
module tb_lz77_match_scheduler;
    localparam int SLEN = 2049;

    typedef struct {
        int off;
        int len;
        int ch;
        bit fin;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] cmp_sb;
    logic [11:0] cmp_lb;
    logic [2:0]  cmp_len;
    logic [11:0] char_addr;
    logic [7:0]  char_data;
    logic        busy;

    logic [7:0]  mem [0:SLEN-1];
    int          mode;
    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;

    lz77_match_scheduler_if tok_if ();

    lz77_match_scheduler u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cmp_sb    (cmp_sb),
        .cmp_lb    (cmp_lb),
        .cmp_len   (cmp_len),
        .char_addr (char_addr),
        .char_data (char_data),
        .tok       (tok_if),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Comparator: 0 = real character compare, 1 = hits only at cursor 20, 2 = hit at off 0 near the end.
    function automatic int cmp_fn(input int sb, input int lb);
        int k;
        int off;
        k = 0;
        off = lb - 1 - sb;
        case (mode)
            0: begin
                while (k < 7 && sb + k >= 0 && lb + k < SLEN && mem[sb + k] == mem[lb + k]) k++;
                return k;
            end
            1: return (lb == 20 && (off == 2 || off == 5)) ? 3 : 0;
            default: return (off == 0) ? ((lb == 1) ? 3 : 7) : 0;
        endcase
    endfunction

    always @(negedge clk) begin
        cmp_len   = 3'(cmp_fn(int'(cmp_sb), int'(cmp_lb)));
        char_data = (int'(char_addr) < SLEN) ? mem[char_addr] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic build_exp();
        int cur;
        int n;
        int bl;
        int bo;
        int l;
        exp_t e;
        exp_q.delete();
        cur = 0;
        while (cur < SLEN) begin
            n  = (cur < 9) ? cur : 9;
            bl = 0;
            bo = 0;
            for (int off = 0; off < n; off++) begin
                l = cmp_fn(cur - 1 - off, cur);
                if (l > 7) l = 7;
                if (l > SLEN - 1 - cur) l = SLEN - 1 - cur;
                if (l > bl) begin
                    bl = l;
                    bo = off;
                end
            end
            e.off = bo;
            e.len = bl;
            e.ch  = int'(mem[cur + bl]);
            e.fin = (mem[cur + bl] == 8'h24);
            exp_q.push_back(e);
            if (e.fin) break;
            cur += bl + 1;
        end
    endtask

    task automatic cmp_tok(input exp_t e, input bit stall);
        chk(stall ? "stall_off"  : "tok_off",  tok_if.tok_offset, e.off);
        chk(stall ? "stall_len"  : "tok_len",  tok_if.tok_len,    e.len);
        chk(stall ? "stall_char" : "tok_char", tok_if.tok_char,   e.ch);
        chk(stall ? "stall_fin"  : "tok_fin",  tok_if.finish,     e.fin);
    endtask

    task automatic chk_zero_outs(input bit mid);
        chk(mid ? "rst_vld"  : "por_vld",  tok_if.tok_valid,  0);
        chk(mid ? "rst_fin"  : "por_fin",  tok_if.finish,     0);
        chk(mid ? "rst_busy" : "por_busy", busy,              0);
        chk(mid ? "rst_off"  : "por_off",  tok_if.tok_offset, 0);
        chk(mid ? "rst_len"  : "por_len",  tok_if.tok_len,    0);
        chk(mid ? "rst_char" : "por_char", tok_if.tok_char,   0);
        chk(mid ? "rst_sb"   : "por_sb",   cmp_sb,            0);
        chk(mid ? "rst_lb"   : "por_lb",   cmp_lb,            0);
        chk(mid ? "rst_addr" : "por_addr", char_addr,         0);
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < SLEN; i++) mem[i] = (i < s.len()) ? s[i] : 8'h7a;
    endtask

    task automatic run_seq(input int stall_idx, input int probe_idx);
        int   idx;
        int   guard;
        bit   done;
        logic [11:0] addr_snap;
        exp_t e;
        build_exp();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        idx  = 0;
        done = 1'b0;
        while (!done) begin
            guard = 0;
            while (!tok_if.tok_valid && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!tok_if.tok_valid) begin
                chk("tok_timeout", tok_if.tok_valid, 1);
                break;
            end
            if (exp_q.size() == 0) begin
                chk("sb_underflow", exp_q.size(), 1);
                break;
            end
            e = exp_q.pop_front();
            if (idx == 0) chk("first_lat", guard, 1);
            if (probe_idx >= 0 && idx == probe_idx + 1) chk("scan_lat", guard, 1);
            cmp_tok(e, 1'b0);
            if (idx == stall_idx) begin
                addr_snap = char_addr;
                for (int k = 0; k < 5; k++) begin
                    start = (k == 0);
                    @(negedge clk);
                    chk("stall_vld", tok_if.tok_valid, 1);
                    cmp_tok(e, 1'b1);
                    chk("stall_addr", char_addr, addr_snap);
                end
                start = 1'b0;
            end
            tok_if.tok_ready = 1'b1;
            @(negedge clk);
            tok_if.tok_ready = 1'b0;
            if (idx == probe_idx) begin
                for (int k = 0; k < 9; k++) begin
                    chk("probe_sb", cmp_sb, 19 - k);
                    chk("probe_lb", cmp_lb, 20);
                    @(negedge clk);
                end
                chk("probe_hold", cmp_sb, 11);
                chk("probe_vld", tok_if.tok_valid, 0);
            end
            idx++;
            if (e.fin) done = 1'b1;
        end
        chk("busy_end", busy, 0);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b0;
        start            = 1'b0;
        tok_if.tok_ready = 1'b0;
        cmp_len          = '0;
        char_data        = '0;
        mode             = 0;
        load_str("ababab$");
        repeat (3) @(negedge clk);
        chk_zero_outs(1'b0);
        reset = 1'b1;
        @(negedge clk);

        // Repeating pattern, one token stalled five cycles with a stray start inside EMIT.
        run_seq(1, -1);

        // Sweep timing and tie-break at cursor 20.
        mode = 1;
        for (int i = 0; i < SLEN; i++) mem[i] = (i < 24) ? 8'(8'h41 + i) : ((i == 24) ? 8'h24 : 8'h7a);
        run_seq(-1, 19);

        // Match clipped by the end of the string.
        mode = 2;
        for (int i = 0; i < SLEN; i++) mem[i] = (i == SLEN - 1) ? 8'h24 : 8'h78;
        run_seq(-1, -1);

        // Asynchronous reset in the middle of a sweep at cursor 30.
        mode = 1;
        for (int i = 0; i < SLEN; i++) mem[i] = (i == SLEN - 1) ? 8'h24 : 8'(8'h61 + (i % 20));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int g = 0; g < 2000; g++) begin
            @(negedge clk);
            if (cmp_lb == 12'd30 && !tok_if.tok_valid && busy) break;
            tok_if.tok_ready = tok_if.tok_valid;
        end
        tok_if.tok_ready = 1'b0;
        chk("rst_reach_lb", cmp_lb, 30);
        chk("rst_reach_busy", busy, 1);
        #2 reset = 1'b0;
        #1 chk_zero_outs(1'b1);
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_vld", tok_if.tok_valid, 0);
        chk("post_rst_busy", busy, 0);

        // Fresh start after reset begins again at cursor 0.
        mode = 0;
        load_str("aaaa$");
        run_seq(-1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/lz77_match_scheduler.md
# lz77_match_scheduler

Sequencing controller for the LZ77 encoder datapath. After the input string (terminated by `'$'`) is buffered, it walks the encode cursor through the string. For each cursor position it sweeps the search-window candidates through the shared match comparator, keeps the longest match, and issues one `(offset, match_len, char_nxt)` token per step over a valid/ready handshake. It owns the `sb`/`lb` index registers that drive the comparator; the string buffer and comparator are external.

## Interface
Parameters:
- `WIMG`, 12: index width into the string buffer.
- `STR_LEN`, 2049: total characters including the terminating `'$'`.
- `SB_LEN`, 9: search-window depth (offsets 0..8).
- `MAX_MATCH`, 7: longest encodable match.
- `END_SGN`, 8'h24: end-of-string character.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse meaning "string buffer loaded"; ignored unless in IDLE.
- `cmp_sb` out WIMG: search-side start index to the comparator.
- `cmp_lb` out WIMG: lookahead start index (equals cursor).
- `cmp_len` in 3: comparator match length for the current `cmp_sb`/`cmp_lb`, valid in the same cycle.
- `char_addr` out WIMG: buffer read address (`cursor + best_len`).
- `char_data` in 8: combinational buffer read data.
- `tok_valid` out 1: token available.
- `tok_ready` in 1: consumer accepts the token.
- `tok_offset` out 4, `tok_len` out 3, `tok_char` out 8: token fields.
- `finish` out 1: high with the final token.
- `busy` out 1: high in any state other than IDLE.

## Operation
States: IDLE, SCAN, FETCH, EMIT.

- IDLE: on `start`, set cursor to 0 and best to 0. Go to FETCH if n = 0, otherwise SCAN.
- SCAN:
  - n = min(cursor, SB_LEN).
  - Each cycle evaluates candidate `off` (0..n-1), with `cmp_sb = cursor-1-off` and `cmp_lb = cursor`.
  - Effective length: `len_eff = min(cmp_len, MAX_MATCH, STR_LEN-1-cursor)`. This guarantees `char_nxt` always exists.
  - Update best only if `len_eff > best_len` (strict), so ties keep the smallest offset. Overlap into the lookahead is allowed.
  - After `off = n-1`, go to FETCH.
- FETCH: drive `char_addr = cursor + best_len`. Register `tok_char <= char_data`, `tok_offset <= best_off`, `tok_len <= best_len`. Set `tok_valid <= 1`. Set `finish <= (char_data == END_SGN)`. Go to EMIT.
- EMIT: hold all token fields stable while `tok_ready = 0`. On handshake:
  - Clear `tok_valid` and `finish`.
  - `cursor += best_len + 1`.
  - Clear best.
  - If `finish` was set, go to IDLE. Otherwise go to SCAN, or to FETCH if the new n = 0.
- The arithmetic stays within WIMG bits. Cursor never exceeds STR_LEN-1, and `cursor + best_len ≤ STR_LEN-1` by the clip rule.
- `start` outside IDLE has no effect.
- The comparator must not be driven outside SCAN: `cmp_sb` and `cmp_lb` hold their last values.

## Timing
- Reset values: `tok_valid` = 0, `finish` = 0, `busy` = 0, `tok_offset` = 0, `tok_len` = 0, `tok_char` = 0, `cmp_sb` = 0, `cmp_lb` = 0, `char_addr` = 0. State is IDLE.
- Reset assertion mid-operation aborts immediately. No partial token is emitted after release.
- Cycles per token: n (SCAN) + 1 (FETCH) + ≥1 (EMIT). First token: `start` at cycle 0, `tok_valid` high at cycle 2.
- `tok_valid` stays high until the handshake. Token fields change only in FETCH.
- `finish` rises and falls with `tok_valid` of the last token.
- `busy` rises the cycle after `start` and falls the cycle after the last handshake.

## Structure
- Shared package `lz77_pkg`:
  - state encoding enum (IDLE/SCAN/FETCH/EMIT);
  - `END_SGN`;
  - width constants `WCHAR` = 8, `WOFF` = 4, `WLEN` = 3, `WIMG` = 12;
  - token struct `{offset, len, char}`.
- One natural sub-module: `lz77_best_match`. It is the running-max tracker holding `best_len`/`best_off`, with clip, strict-greater update and clear. The top-level keeps the FSM, cursor and offset counter.

## Test plan
- STR_LEN=5, string "aaaa$", behavioural comparator → tokens (0,0,'a'), then (0,3,'$') with `finish` = 1. After the handshake, `busy` = 0.
- STR_LEN=7, string "ababab$" → tokens (0,0,'a'), (0,0,'b'), (1,4,'$'). The length 4 results from clipping.
- Forced comparator with cursor = 20: `cmp_len` = 3 at off 2 and off 5, 0 elsewhere → exactly 9 SCAN cycles with `cmp_sb` stepping 19 down to 11; token offset 2, length 3.
- Forced comparator returning 7 at off 0 near the end, with cursor = STR_LEN-4 → `tok_len` = 3, `tok_char` = `'$'`, `finish` = 1.
- Hold `tok_ready` = 0 for 5 cycles during EMIT → `tok_valid` and all fields stable, cursor unchanged; the next token starts after the handshake.
- Drop `reset` to 0 mid-SCAN at cursor = 30 → all outputs 0 and state IDLE at once. A `start` pulse during EMIT is ignored; after reset release, a new `start` restarts from cursor 0.
